// File: rtl/mac_pkg.sv
// Shared types and array geometry for the MAC array issue scheduler.
// The FSM enum is used by the top level; the geometry constants document the array shape.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } sched_state_e;

   // One channel group is a 3x3 window over 4 channels.
   localparam int PRODUCTS_PER_GRP = 36;
   localparam int FILTERS_PER_GRP  = 32;
   localparam int PARTIAL_W        = 22;

endpackage

// File: rtl/mac_loop_cnt.sv
// One loop level of the scheduler: a wrapping counter and an address base
// accumulator that always equals cnt * step.
module mac_loop_cnt #(
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [CNT_W-1:0]  max_i,
   input  logic [ADDR_W-1:0] step_i,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              wrap_o,
   output logic [ADDR_W-1:0] base_o
);

   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;

   assign wrap_o = (cnt_q == max_i);
   assign cnt_o  = cnt_q;
   assign base_o = base_q;

   // The base steps alongside the count, so no multiplier is needed downstream.
   always_comb begin
      cnt_d  = cnt_q;
      base_d = base_q;
      if (clr_i) begin
         cnt_d  = '0;
         base_d = '0;
      end else if (en_i) begin
         if (wrap_o) begin
            cnt_d  = '0;
            base_d = '0;
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            base_d = base_q + step_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         base_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         base_q <= base_d;
      end
   end

endmodule

// File: rtl/mac_array_sched.sv
// Issue scheduler for the 32-filter MAC array: walks channel groups, output pixels
// and filter groups, presents registered buffer reads, then drains the array pipeline.
module mac_array_sched
   import mac_pkg::*;
#(
   parameter int PIX_W   = 16,
   parameter int GRP_W   = 8,
   parameter int FG_W    = 4,
   parameter int ADDR_W  = 20,
   parameter int MAC_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [PIX_W-1:0]  cfg_npix,
   input  logic [GRP_W-1:0]  cfg_ngrp,
   input  logic [FG_W-1:0]   cfg_nfg,
   input  logic              out_rdy,
   output logic              fbuf_re,
   output logic [ADDR_W-1:0] fbuf_addr,
   output logic              wbuf_re,
   output logic [ADDR_W-1:0] wbuf_addr,
   output logic              mac_vld,
   output logic              mac_first,
   output logic              mac_last,
   output logic [PIX_W-1:0]  tag_pix,
   output logic [FG_W-1:0]   tag_fg,
   output logic              busy,
   output logic              done
);

   localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   sched_state_e        state_q, state_d;
   logic [DRAIN_W-1:0]  drainCnt_q, drainCnt_d;
   logic [PIX_W-1:0]    npix_q;
   logic [GRP_W-1:0]    ngrp_q;
   logic [FG_W-1:0]     nfg_q;

   logic                vld_q, first_q, last_q, busy_q, done_q;
   logic [ADDR_W-1:0]   fbufAddr_q, wbufAddr_q;
   logic [PIX_W-1:0]    tagPix_q;
   logic [FG_W-1:0]     tagFg_q;

   logic [GRP_W-1:0]    grpCnt;
   logic [PIX_W-1:0]    pixCnt;
   logic [FG_W-1:0]     fgCnt;
   logic                grpWrap, pixWrap, fgWrap;
   logic [ADDR_W-1:0]   grpBase, pixBase, fgBase;

   logic                cfgZero, launch, fire, pixEn, fgEn, layerEnd;

   assign cfgZero  = (cfg_npix == '0) || (cfg_ngrp == '0) || (cfg_nfg == '0);
   assign launch   = (state_q == IDLE) && start;
   // Only the pixel-completing issue needs writeback space; all others flow freely.
   assign fire     = (state_q == RUN) && (!grpWrap || out_rdy);
   assign pixEn    = fire && grpWrap;
   assign fgEn     = pixEn && pixWrap;
   assign layerEnd = fgEn && fgWrap;

   mac_loop_cnt #(.CNT_W(GRP_W), .ADDR_W(ADDR_W)) uGrpCnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (launch),
      .en_i   (fire),
      .max_i  (ngrp_q - GRP_W'(1)),
      .step_i (ADDR_W'(1)),
      .cnt_o  (grpCnt),
      .wrap_o (grpWrap),
      .base_o (grpBase)
   );

   mac_loop_cnt #(.CNT_W(PIX_W), .ADDR_W(ADDR_W)) uPixCnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (launch),
      .en_i   (pixEn),
      .max_i  (npix_q - PIX_W'(1)),
      .step_i (ADDR_W'(ngrp_q)),
      .cnt_o  (pixCnt),
      .wrap_o (pixWrap),
      .base_o (pixBase)
   );

   mac_loop_cnt #(.CNT_W(FG_W), .ADDR_W(ADDR_W)) uFgCnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (launch),
      .en_i   (fgEn),
      .max_i  (nfg_q - FG_W'(1)),
      .step_i (ADDR_W'(ngrp_q)),
      .cnt_o  (fgCnt),
      .wrap_o (fgWrap),
      .base_o (fgBase)
   );

   always_comb begin
      state_d    = state_q;
      drainCnt_d = drainCnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = cfgZero ? FIN : RUN;
         end
         RUN: begin
            if (layerEnd) begin
               state_d    = DRAIN;
               drainCnt_d = '0;
            end
         end
         DRAIN: begin
            if (drainCnt_q == DRAIN_W'(MAC_LAT - 1)) state_d = FIN;
            else drainCnt_d = drainCnt_q + DRAIN_W'(1);
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         drainCnt_q <= '0;
         npix_q     <= '0;
         ngrp_q     <= '0;
         nfg_q      <= '0;
      end else begin
         state_q    <= state_d;
         drainCnt_q <= drainCnt_d;
         if (launch) begin
            npix_q <= cfg_npix;
            ngrp_q <= cfg_ngrp;
            nfg_q  <= cfg_nfg;
         end
      end
   end

   // Issue fields only load on a fired issue; on a stall or drain they hold with valid low.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q      <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         fbufAddr_q <= '0;
         wbufAddr_q <= '0;
         tagPix_q   <= '0;
         tagFg_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         vld_q  <= fire;
         busy_q <= (state_q == RUN) || (state_q == DRAIN);
         done_q <= (state_q == FIN);
         if (fire) begin
            first_q    <= (grpCnt == '0);
            last_q     <= grpWrap;
            fbufAddr_q <= pixBase + grpBase;
            wbufAddr_q <= fgBase + grpBase;
            tagPix_q   <= pixCnt;
            tagFg_q    <= fgCnt;
         end
      end
   end

   assign fbuf_re   = vld_q;
   assign wbuf_re   = vld_q;
   assign mac_vld   = vld_q;
   assign mac_first = first_q;
   assign mac_last  = last_q;
   assign fbuf_addr = fbufAddr_q;
   assign wbuf_addr = wbufAddr_q;
   assign tag_pix   = tagPix_q;
   assign tag_fg    = tagFg_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mac_array_sched.sv
// Self-checking bench for mac_array_sched: table of layer configs plus hand-written
// stall, reset and restart sequences, with a scoreboard of expected issues.
module tb_mac_array_sched;

   localparam int PIX_W   = 16;
   localparam int GRP_W   = 8;
   localparam int FG_W    = 4;
   localparam int ADDR_W  = 20;
   localparam int MAC_LAT = 4;
   localparam int BUDGET  = 400;

   typedef struct {
      int npix;
      int ngrp;
      int nfg;
      int lowFrom;
      int lowLen;
      int restartAt;
      int expIssues;
      int expLasts;
      int expDone;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] fbuf;
      logic [ADDR_W-1:0] wbuf;
      logic              first;
      logic              last;
      logic [PIX_W-1:0]  pix;
      logic [FG_W-1:0]   fg;
   } iss_t;

   logic              clk = 1'b0;
   logic              rst, start, out_rdy;
   logic [PIX_W-1:0]  cfg_npix;
   logic [GRP_W-1:0]  cfg_ngrp;
   logic [FG_W-1:0]   cfg_nfg;
   logic              fbuf_re, wbuf_re, mac_vld, mac_first, mac_last, busy, done;
   logic [ADDR_W-1:0] fbuf_addr, wbuf_addr;
   logic [PIX_W-1:0]  tag_pix;
   logic [FG_W-1:0]   tag_fg;

   int   checks = 0;
   int   errors = 0;
   int   cyc, issueCnt, lastCnt;
   iss_t expQ[$];
   iss_t lastExp;
   bit   haveLast;
   vec_t vecs[9];

   mac_array_sched #(
      .PIX_W(PIX_W), .GRP_W(GRP_W), .FG_W(FG_W), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_npix  (cfg_npix),
      .cfg_ngrp  (cfg_ngrp),
      .cfg_nfg   (cfg_nfg),
      .out_rdy   (out_rdy),
      .fbuf_re   (fbuf_re),
      .fbuf_addr (fbuf_addr),
      .wbuf_re   (wbuf_re),
      .wbuf_addr (wbuf_addr),
      .mac_vld   (mac_vld),
      .mac_first (mac_first),
      .mac_last  (mac_last),
      .tag_pix   (tag_pix),
      .tag_fg    (tag_fg),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference issue stream built from the loop nest with plain multiplication.
   task automatic pushExpected(input int npix, input int ngrp, input int nfg);
      iss_t e;
      for (int f = 0; f < nfg; f++)
         for (int p = 0; p < npix; p++)
            for (int g = 0; g < ngrp; g++) begin
               e.fbuf  = ADDR_W'(p * ngrp + g);
               e.wbuf  = ADDR_W'(f * ngrp + g);
               e.first = (g == 0);
               e.last  = (g == ngrp - 1);
               e.pix   = PIX_W'(p);
               e.fg    = FG_W'(f);
               expQ.push_back(e);
            end
   endtask

   // Advance to the next falling edge and run the scoreboard on whatever is presented.
   task automatic tick();
      iss_t e;
      @(negedge clk);
      cyc++;
      checkOutput("strobes_aligned", {fbuf_re, wbuf_re}, {mac_vld, mac_vld});
      if (mac_vld === 1'b1) begin
         issueCnt++;
         if (mac_last === 1'b1) lastCnt++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_issue", mac_vld, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("fbuf_addr", fbuf_addr, e.fbuf);
            checkOutput("wbuf_addr", wbuf_addr, e.wbuf);
            checkOutput("mac_first", mac_first, e.first);
            checkOutput("mac_last",  mac_last,  e.last);
            checkOutput("tag_pix",   tag_pix,   e.pix);
            checkOutput("tag_fg",    tag_fg,    e.fg);
            lastExp  = e;
            haveLast = 1;
         end
      end else if (busy === 1'b1 && haveLast) begin
         checkOutput("held_fbuf_addr", fbuf_addr, lastExp.fbuf);
         checkOutput("held_wbuf_addr", wbuf_addr, lastExp.wbuf);
         checkOutput("held_tag_pix",   tag_pix,   lastExp.pix);
         checkOutput("held_tag_fg",    tag_fg,    lastExp.fg);
      end
   endtask

   // Pulse start with the vector's config; the edge that samples it is cycle 0.
   task automatic applyStimulus(input vec_t v);
      issueCnt = 0;
      lastCnt  = 0;
      haveLast = 0;
      pushExpected(v.npix, v.ngrp, v.nfg);
      cfg_npix = PIX_W'(v.npix);
      cfg_ngrp = GRP_W'(v.ngrp);
      cfg_nfg  = FG_W'(v.nfg);
      out_rdy  = 1'b1;
      start    = 1'b1;
      cyc      = -1;
      tick();
      start    = 1'b0;
      checkOutput("busy_at_start", busy, 0);
   endtask

   task automatic runVec(input vec_t v);
      int doneAt;
      doneAt = -1;
      applyStimulus(v);
      while (cyc < BUDGET) begin
         out_rdy = !(v.lowLen > 0 && cyc >= v.lowFrom && cyc < v.lowFrom + v.lowLen);
         start   = (v.restartAt > 0 && cyc == v.restartAt);
         tick();
         if (done === 1'b1) begin
            doneAt = cyc;
            break;
         end
         checkOutput("busy_while_running", busy, 1);
      end
      start   = 1'b0;
      out_rdy = 1'b1;
      checkOutput("done_cycle", doneAt, v.expDone);
      checkOutput("busy_at_done", busy, 0);
      checkOutput("issue_count", issueCnt, v.expIssues);
      checkOutput("last_count", lastCnt, v.expLasts);
      checkOutput("scoreboard_left", expQ.size(), 0);
      expQ.delete();
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("idle_after_done", {done, busy, mac_vld}, 3'b000);
      end
   endtask

   initial begin
      // npix, ngrp, nfg, lowFrom, lowLen, restartAt, issues, lasts, doneCycle
      vecs[0] = '{2, 3, 1, 0, 0, 0,  6, 2, 11};
      vecs[1] = '{1, 2, 3, 0, 0, 0,  6, 3, 11};
      vecs[2] = '{2, 2, 1, 1, 3, 0,  4, 2, 12};
      vecs[3] = '{3, 1, 2, 0, 0, 0,  6, 6, 11};
      vecs[4] = '{1, 1, 1, 0, 0, 0,  1, 1,  6};
      vecs[5] = '{4, 3, 1, 2, 2, 0, 12, 4, 19};
      vecs[6] = '{2, 0, 1, 0, 0, 0,  0, 0,  1};
      vecs[7] = '{2, 3, 1, 0, 0, 3,  6, 2, 11};
      vecs[8] = '{2, 3, 1, 0, 0, 10, 6, 2, 11};

      rst      = 1'b1;
      start    = 1'b0;
      out_rdy  = 1'b1;
      cfg_npix = '0;
      cfg_ngrp = '0;
      cfg_nfg  = '0;
      cyc      = 0;
      haveLast = 0;
      tick();
      tick();
      checkOutput("reset_outputs",
                  {fbuf_re, wbuf_re, mac_vld, mac_first, mac_last, busy, done,
                   fbuf_addr, wbuf_addr, tag_pix, tag_fg}, '0);
      rst = 1'b0;
      tick();

      foreach (vecs[i]) runVec(vecs[i]);

      // A zero filter-group count must also short-circuit to done.
      runVec('{3, 2, 0, 0, 0, 0, 0, 0, 1});

      // Reset in the middle of a 12-issue layer discards it without a done pulse.
      applyStimulus('{4, 3, 1, 0, 0, 0, 12, 4, 19});
      while (issueCnt < 5 && cyc < BUDGET) tick();
      checkOutput("issues_before_reset", issueCnt, 5);
      rst = 1'b1;
      tick();
      checkOutput("outputs_after_reset",
                  {fbuf_re, wbuf_re, mac_vld, mac_first, mac_last, busy, done,
                   fbuf_addr, wbuf_addr, tag_pix, tag_fg}, '0);
      rst = 1'b0;
      expQ.delete();
      haveLast = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checkOutput("quiet_after_reset", {done, mac_vld, busy}, 3'b000);
      end
      runVec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
